lzc_norm_seq: RTL

//  Multi-cycle 64-bit normalizer that time-shares one lzc_32 leading-one detector.

---
 rtl/lzc_norm_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lzc_norm_seq.sv
// Multi-cycle 64-bit normalizer sharing one 32-bit leading-one detector.
// Optional LZC_NORM_EARLY_EXIT_EN skips the low-half pass when the high half is nonzero.
module lzc_32 (
    input  logic [31:0] d,
    output logic [5:0]  cv
);
    always_comb begin
        cv = 6'd0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) cv = {i[4:0], 1'b1};
        end
    end
endmodule

module lzc_norm_seq #(
    parameter int DATA_W     = 64,
    parameter int PIPE_SHIFT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [6:0]        out_count,
    output logic              out_zero
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HI    = 3'd1;
    localparam logic [2:0] LO    = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] data_q;
    logic              v_hi;
    logic [4:0]        lz_hi;
    logic [6:0]        cnt_q;

    logic [31:0]       lzc_in;
    logic [5:0]        lzc_cv;
    logic [4:0]        lz_cur;
    logic [6:0]        cnt_lo;
    logic [6:0]        ld_cnt;
    logic [DATA_W-1:0] shifted;

    lzc_32 u_lzc (
        .d  (lzc_in),
        .cv (lzc_cv)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        lzc_in = (state == LO) ? data_q[DATA_W/2-1:0]
                               : data_q[DATA_W-1:DATA_W/2];
        lz_cur = 5'd31 - lzc_cv[5:1];
        if (v_hi)
            cnt_lo = {2'b00, lz_hi};
        else if (lzc_cv[0])
            cnt_lo = 7'd32 + {2'b00, lz_cur};
        else
            cnt_lo = 7'd64;
        if (state == HI)
            ld_cnt = {2'b00, lz_cur};
        else if (state == SHIFT)
            ld_cnt = cnt_q;
        else
            ld_cnt = cnt_lo;
        // A count of 64 means an all-zero operand; never shift by the full width.
        if (ld_cnt[6])
            shifted = '0;
        else
            shifted = data_q << ld_cnt[5:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data_q    <= '0;
            v_hi      <= 1'b0;
            lz_hi     <= 5'd0;
            cnt_q     <= 7'd0;
            out_data  <= '0;
            out_count <= 7'd0;
            out_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        state  <= HI;
                    end
                end
                HI: begin
                    v_hi  <= lzc_cv[0];
                    lz_hi <= lz_cur;
`ifdef LZC_NORM_EARLY_EXIT_EN
                    if (lzc_cv[0]) begin
                        if (PIPE_SHIFT != 0) begin
                            cnt_q <= ld_cnt;
                            state <= SHIFT;
                        end else begin
                            out_data  <= shifted;
                            out_count <= ld_cnt;
                            out_zero  <= 1'b0;
                            state     <= DONE;
                        end
                    end else begin
                        state <= LO;
                    end
`else
                    state <= LO;
`endif
                end
                LO: begin
                    if (PIPE_SHIFT != 0) begin
                        cnt_q <= ld_cnt;
                        state <= SHIFT;
                    end else begin
                        out_data  <= shifted;
                        out_count <= ld_cnt;
                        out_zero  <= ld_cnt[6];
                        state     <= DONE;
                    end
                end
                SHIFT: begin
                    out_data  <= shifted;
                    out_count <= ld_cnt;
                    out_zero  <= ld_cnt[6];
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
